// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART transmitter
//   tx_state_t : transmitter FSM states (PARITY only with UART_TX_PARITY_EN)
//   PAR_*      : parity_mode encodings (2'b11 also means no parity)
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4
    } tx_state_t;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_ODD  = 2'b01;
    localparam logic [1:0] PAR_EVEN = 2'b10;

endpackage

// File: rtl/uart_tx_param_if.sv
// uart_tx_param_if: ready/valid word channel into the UART transmitter
//   tx_valid : producer has a word on tx_data
//   tx_data  : word to send, DATA_BITS wide
//   tx_ready : transmitter FIFO can take a word
interface uart_tx_param_if #(
    parameter int DATA_BITS = 8
);

    logic                 tx_valid;
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_ready;

    modport master (output tx_valid, output tx_data, input tx_ready);
    modport slave  (input tx_valid, input tx_data, output tx_ready);

endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: synchronous show-ahead FIFO feeding the UART serialiser
//   clk_in, rst : clock and synchronous active-high reset (flushes contents)
//   push, din   : write din when not full
//   pop, dout   : dout is the oldest entry; pop discards it when not empty
//   full, empty : derived from the registered occupancy
//   count       : current occupancy, 0..DEPTH
module uart_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk_in,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full    = count_q == CW'(DEPTH);
    assign empty   = count_q == '0;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem_q[rd_q];
    assign count   = count_q;

    // pointers wrap naturally because DEPTH is a power of two
    always_comb begin
        wr_d    = wr_q + AW'(do_push);
        rd_d    = rd_q + AW'(do_pop);
        count_d = count_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_in) begin
        if (do_push) mem_q[wr_q] <= din;
    end

endmodule

// File: rtl/uart_tx_param.sv
// uart_tx_param: buffered UART transmitter, LSB first, idle-high line
//   clk_in, rst    : clock and synchronous active-high reset
//   baud_tick      : one-cycle pulse per bit period from an external divider
//   tx             : ready/valid word channel (slave side), tx_ready = !full
//   parity_mode    : 00/11 none, 01 odd, 10 even; sampled when a word is popped
//   tx_serial_data : registered serial line
//   tx_busy        : a frame is in progress
//   tx_finish      : one-cycle pulse on the tick closing the last stop bit
//   fifo_count     : FIFO occupancy
// Build option: define UART_TX_PARITY_EN to include the parity bit; without it
// parity_mode is ignored and frames are 1 + DATA_BITS + STOP_BITS ticks.
module uart_tx_param
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk_in,
    input  logic                          rst,
    input  logic                          baud_tick,
    uart_tx_param_if.slave                tx,
    input  logic [1:0]                    parity_mode,
    output logic                          tx_serial_data,
    output logic                          tx_busy,
    output logic                          tx_finish,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int BW = $clog2(DATA_BITS);

    tx_state_t            state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
    logic                 stop_cnt_q, stop_cnt_d;
    logic                 line_q, line_d;
    logic                 busy_q, busy_d;
    logic                 finish_q, finish_d;
    logic                 full, empty, push, pop, last_stop;
    logic [DATA_BITS-1:0] fifo_dout;

`ifdef UART_TX_PARITY_EN
    logic                 par_en_q, par_en_d;
    logic                 par_bit_q, par_bit_d;
`else
    logic                 unused_parity;
    assign unused_parity = ^parity_mode;
`endif

    // ready comes from the registered count, so a full FIFO refuses a push
    // even when a pop happens in the same cycle
    assign tx.tx_ready = !full;
    assign push        = tx.tx_valid && !full;

    uart_tx_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_in (clk_in),
        .rst    (rst),
        .push   (push),
        .pop    (pop),
        .din    (tx.tx_data),
        .dout   (fifo_dout),
        .full   (full),
        .empty  (empty),
        .count  (fifo_count)
    );

    // the tick closing the last stop bit can start the next frame directly
    assign last_stop = state_q == ST_STOP && stop_cnt_q == 1'(STOP_BITS - 1);
    assign pop       = baud_tick && !empty && (state_q == ST_IDLE || last_stop);

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        line_d     = line_q;
        finish_d   = baud_tick && last_stop;
`ifdef UART_TX_PARITY_EN
        par_en_d   = par_en_q;
        par_bit_d  = par_bit_q;
`endif
        if (pop) begin
            state_d = ST_START;
            line_d  = 1'b0;
            shift_d = fifo_dout;
`ifdef UART_TX_PARITY_EN
            par_en_d  = parity_mode == PAR_ODD || parity_mode == PAR_EVEN;
            par_bit_d = ^fifo_dout ^ (parity_mode == PAR_ODD);
`endif
        end else if (baud_tick) begin
            case (state_q)
                ST_START: begin
                    state_d   = ST_DATA;
                    line_d    = shift_q[0];
                    shift_d   = shift_q >> 1;
                    bit_cnt_d = '0;
                end
                ST_DATA: begin
                    if (bit_cnt_q == BW'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
                        if (par_en_q) begin
                            state_d = ST_PARITY;
                            line_d  = par_bit_q;
                        end else begin
                            state_d    = ST_STOP;
                            line_d     = 1'b1;
                            stop_cnt_d = 1'b0;
                        end
`else
                        state_d    = ST_STOP;
                        line_d     = 1'b1;
                        stop_cnt_d = 1'b0;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        line_d    = shift_q[0];
                        shift_d   = shift_q >> 1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                ST_PARITY: begin
                    state_d    = ST_STOP;
                    line_d     = 1'b1;
                    stop_cnt_d = 1'b0;
                end
`endif
                ST_STOP: begin
                    if (last_stop) begin
                        state_d = ST_IDLE;
                        line_d  = 1'b1;
                    end else begin
                        stop_cnt_d = stop_cnt_q + 1'b1;
                    end
                end
                default: line_d = 1'b1;
            endcase
        end
        busy_d = state_d != ST_IDLE;
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            line_q     <= 1'b1;
            busy_q     <= 1'b0;
            finish_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            line_q     <= line_d;
            busy_q     <= busy_d;
            finish_q   <= finish_d;
`ifdef UART_TX_PARITY_EN
            par_en_q   <= par_en_d;
            par_bit_q  <= par_bit_d;
`endif
        end
    end

    assign tx_serial_data = line_q;
    assign tx_busy        = busy_q;
    assign tx_finish      = finish_q;

endmodule
